// File: rtl/rv32i_dmem_bridge.sv
// Data-memory bridge: turns a registered load/store request from the memory stage into
// one strobe/ack bus transaction, with pipeline stall, timeout abort and flush handling.
module rv32i_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wmask,
  input  logic        i_flush,
  input  logic        i_hold,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_bus_err,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        killed_q, killed_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        kill_now;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    killed_d  = killed_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    // A flush in the same cycle as the ack or timeout already counts as a kill.
    kill_now  = killed_q | i_flush;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && !i_flush) begin
          addr_d   = i_req_addr & 32'hFFFF_FFFC;
          wdata_d  = i_req_wdata;
          sel_d    = i_req_wmask;
          we_d     = i_req_we;
          stb_d    = 1'b1;
          cnt_d    = 16'd0;
          killed_d = 1'b0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        killed_d = kill_now;
        if (i_mem_ack && stb_q) begin
          stb_d = 1'b0;
          if (!we_q && !kill_now) begin
            rdata_d = i_mem_rdata;
          end
          state_d = kill_now ? ST_IDLE : ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          stb_d = 1'b0;
          if (kill_now) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d   = 32'd0;
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        if (!(i_hold && !i_flush)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      killed_q  <= 1'b0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      killed_q  <= killed_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
    end
  end

  assign o_stall     = ((state_q == ST_IDLE) && i_req_valid && !i_flush) || (state_q == ST_BUSY);
  assign o_done      = (state_q == ST_DONE);
  assign o_rdata     = rdata_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_stb   = stb_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_sel   = sel_q;

endmodule
